seg7_scan_mux: RTL
==================

Name: seg7_scan_mux

Overview:
- Downstream display stage for the seconds counter.
- Takes NUM_DIGITS packed BCD digits and time-multiplexes them onto one shared 7-segment bus with one-hot digit selects.
- Double-buffers loads so a frame never tears, and inserts a blanking gap between digits to suppress ghosting.
- Segment encoding comes from the existing seg7 decoder.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- DWELL_CYCLES, 1000, clk cycles each digit is driven (>=1).
- BLANK_CYCLES, 16, clk cycles all digits are off before each digit (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- bcd_in  input  4*NUM_DIGITS  packed digits; [3:0] is digit 0 (rightmost).
- dp_in  input  NUM_DIGITS  decimal point per digit.
- load  input  1  capture bcd_in/dp_in into the pending buffer this cycle.
- segments  output  7  bit0=a .. bit6=g; active-high, registered.
- dp  output  1  decimal point for the active digit; registered.
- digit_sel  output  NUM_DIGITS  one-hot active-high digit enable; registered.
- frame_start  output  1  one-cycle pulse on entry to BLANK of digit 0.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset), sampled on the rising edge of clk.
- Reset state:
  - FSM = BLANK, digit index = 0, timer = 0.
  - Active and pending buffers = 0, pending_valid = 0.
  - segments = 0, dp = 0, digit_sel = 0, frame_start = 0.
- FSM has two states, BLANK and DRIVE.
  - BLANK: digit_sel = 0, segments = 0, dp = 0. Lasts exactly BLANK_CYCLES cycles, then goes to DRIVE and clears the timer.
  - DRIVE: digit_sel = 1 << index; segments = seg7(active digit[index]); dp = active dp[index]. Lasts exactly DWELL_CYCLES cycles, then goes to BLANK and clears the timer.
  - On DRIVE->BLANK, index increments. index NUM_DIGITS-1 wraps to 0.
  - Frame length = NUM_DIGITS*(BLANK_CYCLES+DWELL_CYCLES) cycles.
- Timer is an unsigned counter of width clog2(max(DWELL_CYCLES, BLANK_CYCLES)+1). It never exceeds its terminal count.
- Outputs are registered. digit_sel, segments and dp change on the same clock edge; there is never a cycle with a new select and stale segments.
- Digit codes 10..15 decode to segments = 0 (blank), overriding seg7 output for those codes. dp still follows dp_in.
- Load and commit:
  - load=1 stores bcd_in/dp_in into pending and sets pending_valid. Repeated loads before commit: the last one wins.
  - Commit happens on the DRIVE->BLANK transition out of index NUM_DIGITS-1, i.e. the frame boundary. pending is copied to active and pending_valid is cleared.
  - If load=1 in the commit cycle, bcd_in/dp_in are committed directly (bypass). pending_valid ends 0.
  - With no pending data at the boundary, active is unchanged.
- frame_start is asserted for one cycle while the FSM is in the first BLANK cycle of index 0. That cycle is the first cycle after reset release and every frame thereafter. The active buffer already holds the committed value in that cycle.
- Reset mid-frame: next cycle returns to the reset state, and any pending data is discarded.

Optional Feature:
- Macro: SEG7_SCAN_LZB_EN (leading-zero blanking).
- Defined:
  - During DRIVE, digit index i (i>0) shows segments = 0 if active digits i..NUM_DIGITS-1 are all 0.
  - Digit 0 is never blanked.
  - dp is not affected; digit_sel still asserts, so timing is unchanged.
- Undefined: zeros are displayed normally.

Decomposition:
- Package seg7_scan_pkg holds:
  - SEG_BLANK = 7'b0.
  - Function for the one-hot select from index.
  - localparam helpers for timer width and frame length.
- Sub-module: the existing seg7 decoder, instantiated once on the muxed active digit.
- FSM, buffers and blanking logic stay in seg7_scan_mux.

Test Plan (NUM_DIGITS=4, DWELL_CYCLES=8, BLANK_CYCLES=2, frame 40 cycles):
- Reset release, load=0 -> frame_start high on cycle 0. Cycles 0-1: digit_sel=0000. Cycles 2-9: digit_sel=0001, segments=seg7(0). Cycle 10: digit_sel=0000. Cycle 12: digit_sel=0010. frame_start recurs at cycle 40.
- load bcd_in=16'h1234 at cycle 5 -> frame 0 still shows 0s. From cycle 40: digit 0 shows 4, digit 3 shows 1.
- load 16'h1111 at cycle 20, then 16'h5678 at cycle 30 -> next frame shows 5678 only.
- load 16'h9999 exactly on the commit cycle (last DRIVE cycle of digit 3) -> the following frame shows 9999.
- bcd_in=16'h00A7, dp_in=4'b0100 -> digit 1 segments=0, digit 2 dp=1. With SEG7_SCAN_LZB_EN, digits 2-3 segments=0 and digit 2 dp=1; without it, digits 2-3 show 0.
- reset asserted for 1 cycle at cycle 15 with pending 16'h4321 -> outputs 0 next cycle. Next frame shows 0000.

Source files
------------

// File: rtl/seg7_scan_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scanner.
// The state enum, the blank segment code, the digit one-hot select and
// sizing helpers for the dwell/blank timer and frame length.
package seg7_scan_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

  localparam logic [6:0] SEG_BLANK  = 7'b0;
  localparam int         MAX_DIGITS = 8;

  // One-hot digit enable for a digit index (0..MAX_DIGITS-1).
  function automatic logic [MAX_DIGITS-1:0] digit_onehot(input logic [2:0] idx);
    return MAX_DIGITS'(1) << idx;
  endfunction

  // Width of a timer that must reach max(dwell, blank) without overflow.
  function automatic int timer_width(input int dwell, input int blank);
    return $clog2(((dwell > blank) ? dwell : blank) + 1);
  endfunction

  // Clock cycles in one full scan of all digits.
  function automatic int frame_cycles(input int n, input int dwell, input int blank);
    return n * (dwell + blank);
  endfunction

endpackage

// File: rtl/seg7.sv
// Hex digit to 7-segment decoder, bit0=a .. bit6=g, active-high.
module seg7 (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Pure lookup of the segment pattern for each nibble value.
  always_comb begin
    seg = 7'h00;
    case (bcd)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed 7-segment scanner with double-buffered frame loads and
// a blanking gap before every digit. Optional leading-zero blanking is
// enabled by defining SEG7_SCAN_LZB_EN.
module seg7_scan_mux
  import seg7_scan_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  output logic [6:0]              segments,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_start
);

  localparam int              TW         = timer_width(DWELL_CYCLES, BLANK_CYCLES);
  localparam int              IW         = $clog2(NUM_DIGITS);
  localparam logic [TW-1:0]   BLANK_LAST = TW'(BLANK_CYCLES - 1);
  localparam logic [TW-1:0]   DWELL_LAST = TW'(DWELL_CYCLES - 1);
  localparam logic [IW-1:0]   IDX_LAST   = IW'(NUM_DIGITS - 1);

  scan_state_e               state_q, state_d;
  logic [TW-1:0]             timer_q, timer_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0]   act_bcd_q, act_bcd_d, pend_bcd_q, pend_bcd_d;
  logic [NUM_DIGITS-1:0]     act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic                      pend_vld_q, pend_vld_d;
  logic [6:0]                segments_q, segments_d;
  logic                      dp_q, dp_d;
  logic [NUM_DIGITS-1:0]     digit_sel_q, digit_sel_d;
  logic                      frame_start_q, frame_start_d;

  logic                      boundary;
  logic [3:0]                cur_bcd;
  logic                      cur_dp;
  logic [6:0]                dec_seg;
  logic                      lz_blank;

  // Sequencer: BLANK for BLANK_CYCLES, then DRIVE for DWELL_CYCLES, next digit.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + TW'(1);
    idx_d   = idx_q;
    case (state_q)
      ST_BLANK: begin
        if (timer_q == BLANK_LAST) begin
          state_d = ST_DRIVE;
          timer_d = '0;
        end
      end
      ST_DRIVE: begin
        if (timer_q == DWELL_LAST) begin
          state_d = ST_BLANK;
          timer_d = '0;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
      end
      default: begin
        state_d = ST_BLANK;
        timer_d = '0;
      end
    endcase
  end

  // Frame boundary: the sequencer sits in digit 0's first blank cycle. The
  // outputs trail the sequencer by one register, so this is the cycle in
  // which the bus still shows the last dwell cycle of digit NUM_DIGITS-1.
  assign boundary = (state_q == ST_BLANK) && (timer_q == '0) && (idx_q == '0);

  // Double buffer: loads land in pending; pending (or a same-cycle load) is
  // promoted to active only at the frame boundary so a frame never tears.
  always_comb begin
    act_bcd_d  = act_bcd_q;
    act_dp_d   = act_dp_q;
    pend_bcd_d = pend_bcd_q;
    pend_dp_d  = pend_dp_q;
    pend_vld_d = pend_vld_q;
    if (boundary) begin
      if (load) begin
        act_bcd_d  = bcd_in;
        act_dp_d   = dp_in;
        pend_vld_d = 1'b0;
      end else if (pend_vld_q) begin
        act_bcd_d  = pend_bcd_q;
        act_dp_d   = pend_dp_q;
        pend_vld_d = 1'b0;
      end
    end else if (load) begin
      pend_bcd_d = bcd_in;
      pend_dp_d  = dp_in;
      pend_vld_d = 1'b1;
    end
  end

  // Select the active digit and its decimal point for the current index.
  always_comb begin
    cur_bcd = 4'h0;
    cur_dp  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_bcd = act_bcd_q[4*i +: 4];
        cur_dp  = act_dp_q[i];
      end
    end
  end

  seg7 u_seg7 (
    .bcd (cur_bcd),
    .seg (dec_seg)
  );

`ifdef SEG7_SCAN_LZB_EN
  // Blank digit idx when it and every more significant digit are zero.
  always_comb begin
    lz_blank = (idx_q != '0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((IW'(i) >= idx_q) && (act_bcd_q[4*i +: 4] != 4'h0)) begin
        lz_blank = 1'b0;
      end
    end
  end
`else
  assign lz_blank = 1'b0;
`endif

  // Output decode; select, segments and dp are all registered together.
  always_comb begin
    segments_d    = SEG_BLANK;
    dp_d          = 1'b0;
    digit_sel_d   = '0;
    frame_start_d = boundary;
    if (state_q == ST_DRIVE) begin
      digit_sel_d = NUM_DIGITS'(digit_onehot(3'(idx_q)));
      dp_d        = cur_dp;
      segments_d  = ((cur_bcd > 4'd9) || lz_blank) ? SEG_BLANK : dec_seg;
    end
  end

  // State, buffers and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_BLANK;
      timer_q       <= '0;
      idx_q         <= '0;
      act_bcd_q     <= '0;
      act_dp_q      <= '0;
      pend_bcd_q    <= '0;
      pend_dp_q     <= '0;
      pend_vld_q    <= 1'b0;
      segments_q    <= SEG_BLANK;
      dp_q          <= 1'b0;
      digit_sel_q   <= '0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      idx_q         <= idx_d;
      act_bcd_q     <= act_bcd_d;
      act_dp_q      <= act_dp_d;
      pend_bcd_q    <= pend_bcd_d;
      pend_dp_q     <= pend_dp_d;
      pend_vld_q    <= pend_vld_d;
      segments_q    <= segments_d;
      dp_q          <= dp_d;
      digit_sel_q   <= digit_sel_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign segments    = segments_q;
  assign dp          = dp_q;
  assign digit_sel   = digit_sel_q;
  assign frame_start = frame_start_q;

endmodule
